// File: rtl/rr_arb4_sel.sv
// Four-channel round-robin arbiter steering the select of an external 4:1 mux.
// A grant is held for at most MAX_BURST accepted beats, then priority rotates past the winner.
module rr_arb4_sel #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  logic [3:0]       grant_reg;
  logic [1:0]       sel_reg;
  logic             busy_reg;
  logic [1:0]       ptr_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [1:0] win_idx;
  logic [1:0] cand;
  logic [3:0] win_onehot;
  logic       xfer;
  logic       release_now;

  // Scan from farthest to nearest so the channel closest after ptr wins.
  always_comb begin
    win_idx = ptr_reg;
    cand    = ptr_reg;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_reg + 2'(k);
      if (req[cand]) win_idx = cand;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == 2'(gi));
    end
  endgenerate

  assign out_valid   = busy_reg & req[sel_reg];
  assign xfer        = out_valid & out_ready;
  assign release_now = ~req[sel_reg] | (xfer & (cnt_reg == LAST_BEAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_reg <= 4'b0000;
      sel_reg   <= 2'd0;
      busy_reg  <= 1'b0;
      ptr_reg   <= 2'd3;
      cnt_reg   <= '0;
    end else if (!busy_reg) begin
      if (req != 4'b0000) begin
        grant_reg <= win_onehot;
        sel_reg   <= win_idx;
        busy_reg  <= 1'b1;
        cnt_reg   <= '0;
      end
    end else if (release_now) begin
      // sel is deliberately left alone so the mux does not move on release.
      ptr_reg   <= sel_reg;
      grant_reg <= 4'b0000;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else if (xfer) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign grant = grant_reg;
  assign sel   = sel_reg;
  assign busy  = busy_reg;

endmodule
